// File: rtl/rst_seq_ctl_if.sv
// Control/status bundle between the reset sequencer and the board: PLL lock in,
// soft restart in, PLL reset and per-domain resets out.
interface rst_seq_ctl_if #(
  parameter int N_STAGES = 3,
  parameter int RW       = 2
);
  logic                pll_locked_i;
  logic                soft_rst_i;
  logic                pll_rst_o;
  logic [N_STAGES-1:0] rst_n_o;
  logic                ready_o;
  logic                fail_o;
  logic [RW-1:0]       retry_cnt_o;

  modport master (
    output pll_locked_i,
    output soft_rst_i,
    input  pll_rst_o,
    input  rst_n_o,
    input  ready_o,
    input  fail_o,
    input  retry_cnt_o
  );

  modport slave (
    input  pll_locked_i,
    input  soft_rst_i,
    output pll_rst_o,
    output rst_n_o,
    output ready_o,
    output fail_o,
    output retry_cnt_o
  );
endinterface

// File: rtl/rst_seq_ctl.sv
// PLL bring-up and ordered reset-release sequencer, clocked by the free-running
// board clock; retries PLL lock with a timeout and restarts on lock loss.
module rst_seq_ctl #(
  parameter int N_STAGES       = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int LOCK_STABLE    = 256,
  parameter int STAGE_GAP      = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rst_seq_ctl_if.slave  bus
);

  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                pll_rst_q, pll_rst_d;
  logic [N_STAGES-1:0] rst_n_q, rst_n_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;
  logic                sync1_q, lock_s_q;
  logic [N_STAGES-1:0] rst_n_shift;

  // Releasing a stage shifts a one in from the bottom, keeping the vector thermometer-coded.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_shift
    if (gi == 0) begin : g_first
      assign rst_n_shift[gi] = 1'b1;
    end else begin : g_next
      assign rst_n_shift[gi] = rst_n_q[gi-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    rst_n_d   = rst_n_q;
    ready_d   = ready_q;
    fail_d    = fail_q;

    if (bus.soft_rst_i) begin
      state_d   = PLL_RST;
      cnt_d     = '0;
      retry_d   = '0;
      pll_rst_d = 1'b1;
      rst_n_d   = '0;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          pll_rst_d = 1'b1;
          rst_n_d   = '0;
          ready_d   = 1'b0;
          if (cnt_q == PLL_LAST) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end
        end

        WAIT_LOCK: begin
          // Lock seen on the timeout cycle wins over the retry.
          if (lock_s_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + RW'(1);
            end
          end
        end

        STABLE: begin
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end

        RELEASE: begin
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            rst_n_d = rst_n_shift;
            if (&rst_n_shift) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end
        end

        RUN: begin
          cnt_d = '0;
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            rst_n_d = '0;
            ready_d = 1'b0;
          end
        end

        FAIL: begin
          cnt_d     = '0;
          fail_d    = 1'b1;
          pll_rst_d = 1'b1;
          rst_n_d   = '0;
          ready_d   = 1'b0;
        end

        default: begin
          state_d   = PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          rst_n_d   = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      rst_n_q   <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      sync1_q   <= bus.pll_locked_i;
      lock_s_q  <= sync1_q;
    end
  end

  assign bus.pll_rst_o   = pll_rst_q;
  assign bus.rst_n_o     = rst_n_q;
  assign bus.ready_o     = ready_q;
  assign bus.fail_o      = fail_q;
  assign bus.retry_cnt_o = retry_q;

endmodule
